// File: rtl/ssp_arb_pkg.sv
// ssp_arb_pkg: shared SSP arbiter types and sizing; SSP_ARB_TAG_EN selects 9-bit tagged frames
package ssp_arb_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  localparam int SSP_HALF_PERIOD = 4;
  localparam int SSP_GAP_CYCLES = 8;
  localparam int SSP_DATA_BITS = 8;
`ifdef SSP_ARB_TAG_EN
  localparam int SSP_FRAME_BITS = SSP_DATA_BITS + 1;
`else
  localparam int SSP_FRAME_BITS = SSP_DATA_BITS;
`endif
  localparam int SSP_PH_W = $clog2(2 * SSP_HALF_PERIOD);
  localparam int SSP_IDX_W = $clog2(SSP_FRAME_BITS);
  localparam int SSP_GAP_W = $clog2(SSP_GAP_CYCLES);
endpackage

// File: rtl/ssp_bit_timer.sv
// ssp_bit_timer: per-bit phase counter and bit index, producing ssp_clk and rise/wrap/last strobes
module ssp_bit_timer
  import ssp_arb_pkg::*;
(
  input  logic ck_1356meg,
  input  logic rst,
  input  logic start,
  input  logic run,
  output logic ssp_clk,
  output logic rise,
  output logic wrap,
  output logic last
);
  logic [SSP_PH_W-1:0] phase, phase_n;
  logic [SSP_IDX_W-1:0] idx;
  always_comb begin
    phase_n = start ? '0 : run ? phase + 1'b1 : phase;
    rise = run && phase == SSP_PH_W'(SSP_HALF_PERIOD);
    wrap = run && phase == SSP_PH_W'(2 * SSP_HALF_PERIOD - 1);
    last = idx == SSP_IDX_W'(SSP_FRAME_BITS - 1);
  end
  // ssp_clk is registered from the next phase so it lines up with the phase it describes
  always_ff @(posedge ck_1356meg or posedge rst)
    if (rst) begin
      phase <= '0;
      idx <= '0;
      ssp_clk <= 1'b0;
    end else begin
      phase <= phase_n;
      idx <= start ? '0 : wrap ? idx + 1'b1 : idx;
      ssp_clk <= phase_n >= SSP_PH_W'(SSP_HALF_PERIOD);
    end
endmodule

// File: rtl/ssp_arbiter.sv
// ssp_arbiter: round-robin share of the SSP link between two byte requesters; SSP_ARB_TAG_EN prefixes a channel tag bit
module ssp_arbiter
  import ssp_arb_pkg::*;
(
  input  logic       ck_1356meg,
  input  logic       rst,
  input  logic       enable,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       ack0,
  output logic       ack1,
  output logic       ssp_clk,
  output logic       ssp_frame,
  output logic       ssp_din,
  input  logic       ssp_dout,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       grant_ch
);
  state_t state, state_n;
  logic grant, win, last_ch, done, rise, wrap, last;
  logic [SSP_DATA_BITS-1:0] data_w, rx_sr;
  logic [SSP_FRAME_BITS-1:0] tx_sr;
  logic [SSP_GAP_W-1:0] gap_cnt;

  ssp_bit_timer u_timer (
    .ck_1356meg(ck_1356meg),
    .rst(rst),
    .start(grant),
    .run(state == SHIFT),
    .ssp_clk(ssp_clk),
    .rise(rise),
    .wrap(wrap),
    .last(last)
  );

  always_ff @(posedge ck_1356meg or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;

  always_comb
    state_n = state == IDLE  ? (grant ? SHIFT : IDLE) :
              state == SHIFT ? (done ? GAP : SHIFT) :
              (gap_cnt == SSP_GAP_W'(SSP_GAP_CYCLES - 1) ? IDLE : GAP);

  // on contention the channel not served last wins
  always_comb begin
    win = (req0 && req1) ? ~last_ch : req1;
    grant = state == IDLE && enable && (req0 || req1);
    data_w = win ? data1 : data0;
    done = wrap && last;
  end

  assign ssp_din = tx_sr[SSP_FRAME_BITS-1];

  always_ff @(posedge ck_1356meg or posedge rst)
    if (rst) begin
      last_ch <= 1'b1;
      grant_ch <= 1'b0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      busy <= 1'b0;
      ssp_frame <= 1'b0;
      tx_sr <= '0;
      rx_sr <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      gap_cnt <= '0;
    end else begin
      busy <= state_n != IDLE;
      ack0 <= grant && !win;
      ack1 <= grant && win;
      rx_valid <= done;
      gap_cnt <= state == GAP ? gap_cnt + 1'b1 : '0;
      if (grant) begin
        grant_ch <= win;
        last_ch <= win;
        ssp_frame <= 1'b1;
`ifdef SSP_ARB_TAG_EN
        tx_sr <= {win, data_w};
`else
        tx_sr <= data_w;
`endif
      end else if (wrap) begin
        ssp_frame <= 1'b0;
        tx_sr <= tx_sr << 1;
      end
      if (rise) rx_sr <= {rx_sr[SSP_DATA_BITS-2:0], ssp_dout};
      if (done) rx_data <= rx_sr;
    end
endmodule

// File: tb/tb_ssp_arbiter.sv
// tb_ssp_arbiter: frame-schedule model compared every cycle, plus directed literal checks
module tb_ssp_arbiter;
`ifdef SSP_ARB_TAG_EN
  localparam int FB = 9;
  localparam int SPACING = 81;
`else
  localparam int FB = 8;
  localparam int SPACING = 73;
`endif
  localparam int FL = FB * 8;
  localparam int OFF = FB - 8;

  logic ck_1356meg = 0, rst = 1, enable = 0, req0 = 0, req1 = 0, ssp_dout = 0;
  logic [7:0] data0 = 0, data1 = 0;
  logic ack0, ack1, ssp_clk, ssp_frame, ssp_din, rx_valid, busy, grant_ch;
  logic [7:0] rx_data;

  ssp_arbiter dut (
    .ck_1356meg(ck_1356meg), .rst(rst), .enable(enable), .req0(req0), .req1(req1),
    .data0(data0), .data1(data1), .ack0(ack0), .ack1(ack1), .ssp_clk(ssp_clk),
    .ssp_frame(ssp_frame), .ssp_din(ssp_din), .ssp_dout(ssp_dout), .rx_data(rx_data),
    .rx_valid(rx_valid), .busy(busy), .grant_ch(grant_ch)
  );

  always #5 ck_1356meg = ~ck_1356meg;

  int checks = 0, errors = 0, cyc = 0, n_start = -1000;
  logic m_ch = 0, m_last = 1;
  logic [7:0] m_byte = 0, m_rx = 0, arm_byte = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // model: a frame granted in cycle n_start occupies the FL+8 cycles that follow it
  always @(posedge ck_1356meg) begin
    if (rst) begin
      n_start = -1000;
      m_last = 1;
      m_ch = 0;
      m_rx = 0;
    end else if (cyc - n_start >= FL + 9 && enable && (req0 || req1)) begin
      m_ch = (req0 && req1) ? ~m_last : req1;
      m_last = m_ch;
      m_byte = m_ch ? data1 : data0;
      n_start = cyc;
    end
    cyc++;
    if (!rst && cyc - n_start == FL + 1) m_rx = arm_byte;
  end

  function automatic logic [FB-1:0] word_of(input logic tag, input logic [7:0] b);
`ifdef SSP_ARB_TAG_EN
    return {tag, b};
`else
    return tag ? b : b;
`endif
  endfunction

  // ARM side: one bit per 8-cycle slot, changing as ssp_clk falls
  int ad;
  logic [FB-1:0] aw;
  always @(negedge ck_1356meg) begin
    ad = cyc - n_start;
    aw = word_of(1'b1, arm_byte);
    ssp_dout = (ad >= 1 && ad <= FL) ? aw[FB-1-(ad-1)/8] : 1'b0;
  end

  int d, slot;
  logic en, inf;
  logic [FB-1:0] txw;
  always @(negedge ck_1356meg) begin
    #1;
    d = cyc - n_start;
    en = !rst;
    inf = d >= 1 && d <= FL;
    slot = inf ? (d - 1) / 8 : 0;
    txw = word_of(m_ch, m_byte);
    chk("busy", busy, en && d >= 1 && d <= FL + 8);
    chk("ack0", ack0, en && d == 1 && !m_ch);
    chk("ack1", ack1, en && d == 1 && m_ch);
    chk("ssp_frame", ssp_frame, en && d >= 1 && d <= 8);
    chk("ssp_clk", ssp_clk, en && inf && (d - 1) % 8 >= 4);
    chk("ssp_din", ssp_din, en && inf && txw[FB-1-slot]);
    chk("rx_valid", rx_valid, en && d == FL + 1);
    chk("rx_data", rx_data, en ? m_rx : 8'h00);
    chk("grant_ch", grant_ch, en && m_ch);
  end

  task automatic tick();
    @(negedge ck_1356meg);
    #2;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic wait_ack(output int t, output logic ch);
    t = -1;
    ch = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (ack0 || ack1) begin
        t = cyc;
        ch = ack1;
        break;
      end
    end
    chk("ack_seen", t >= 0, 1);
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  int t, t2, c0;
  logic ch;
  logic [7:0] pat;
  initial begin
    repeat (3) tick();
    rst = 0;
    tick();
    chk("reset_outs", {ack0, ack1, ssp_clk, ssp_frame, ssp_din, rx_valid, busy, grant_ch, rx_data}, 0);
    enable = 1;
    data0 = 8'hA5;
    req0 = 1;
    wait_ack(t, ch);
    req0 = 0;
    chk("single_ch", ch, 0);
    chk("single_frame_first", ssp_frame, 1);
    chk("single_busy_first", busy, 1);
    pat = 8'b1010_0101;
    for (int k = 0; k < 8; k++) begin
      wait_until(t + 8 * (k + OFF) + 4);
      chk("single_din", ssp_din, pat[7-k]);
      chk("single_frame", ssp_frame, (k + OFF) == 0);
    end
    wait_until(t + FL + 7);
    chk("single_busy_gap", busy, 1);
    wait_until(t + FL + 8);
    chk("single_busy_end", busy, 0);

    do_reset();
    data0 = 8'h11;
    data1 = 8'h22;
    req0 = 1;
    req1 = 1;
    for (int i = 0; i < 4; i++) begin
      wait_ack(t2, ch);
      chk("cont_ch", ch, i % 2);
      chk("cont_grant_ch", grant_ch, i % 2);
      if (i > 0) chk("cont_spacing", t2 - t, SPACING);
      t = t2;
    end
    req0 = 0;
    req1 = 0;
    wait_until(t + FL + 9);

    arm_byte = 8'hDE;
    data0 = 8'h00;
    req0 = 1;
    wait_ack(t, ch);
    req0 = 0;
    wait_until(t + FL - 1);
    chk("rx_valid_early", rx_valid, 0);
    wait_until(t + FL);
    chk("rx_valid_pulse", rx_valid, 1);
    chk("rx_data_de", rx_data, 8'hDE);
    wait_until(t + FL + 1);
    chk("rx_valid_once", rx_valid, 0);
    wait_until(t + FL + 9);

    data1 = 8'h5A;
    req1 = 1;
    wait_ack(t, ch);
    chk("en_first_ch", ch, 1);
    wait_until(t + 19);
    enable = 0;
    wait_until(t + FL + 20);
    chk("en_idle", busy, 0);
    chk("en_no_ack", ack1, 0);
    enable = 1;
    c0 = cyc;
    wait_ack(t2, ch);
    chk("en_resume_ch", ch, 1);
    chk("en_resume_lat", (t2 - c0) <= 2, 1);
    req1 = 0;
    wait_until(t2 + FL + 9);

    arm_byte = 8'hFF;
    data0 = 8'h3C;
    req0 = 1;
    wait_ack(t, ch);
    req0 = 0;
    wait_until(t + 29);
    rst = 1;
    #1;
    chk("rst_async_outs", {ack0, ack1, ssp_clk, ssp_frame, ssp_din, rx_valid, busy, grant_ch, rx_data}, 0);
    data0 = 8'h11;
    data1 = 8'h22;
    req0 = 1;
    req1 = 1;
    tick();
    tick();
    rst = 0;
    wait_ack(t, ch);
    chk("rst_first_ch", ch, 0);
    chk("rst_grant_ch", grant_ch, 0);
    req0 = 0;
    req1 = 0;
    wait_until(t + FL + 9);

`ifdef SSP_ARB_TAG_EN
    data1 = 8'hFF;
    req1 = 1;
    wait_ack(t, ch);
    for (int k = 0; k < 9; k++) begin
      wait_until(t + 8 * k + 4);
      chk("tag_din", ssp_din, 1);
      chk("tag_frame", ssp_frame, k == 0);
    end
    wait_ack(t2, ch);
    chk("tag_spacing", t2 - t, 81);
    req1 = 0;
    wait_until(t2 + FL + 9);
`endif
    repeat (4) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ssp_arbiter.md
# ssp_arbiter

Shares the single SSP link to the ARM between two byte-wide requesters, such as the demodulator stream and a test/status pattern source. The block grants the link round-robin and serialises the granted byte MSB-first while generating ssp_clk and ssp_frame. It captures the ARM's ssp_dout bits of the same frame into a receive byte. It sits between the mode modules and the top-level SSP pins, and replaces ad-hoc per-mode muxing of ssp_clk, ssp_frame and ssp_din.

## Interface
- No parameters; all sizing constants come from the shared package.
- ck_1356meg  in  1  13.56 MHz carrier clock; the only clock.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  when low, no new grants; a frame already in flight completes.
- req0, req1  in  1  request from channel 0 / 1; held until the matching ack.
- data0, data1  in  8  byte to send; must be stable while req is high.
- ack0, ack1  out  1  one-cycle pulse: byte taken, requester may change data.
- ssp_clk  out  1  SSP bit clock to the ARM.
- ssp_frame  out  1  frame marker to the ARM.
- ssp_din  out  1  serial data to the ARM (FPGA→ARM).
- ssp_dout  in  1  serial data from the ARM (ARM→FPGA).
- rx_data  out  8  last byte received from the ARM.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- busy  out  1  high whenever the state is not IDLE.
- grant_ch  out  1  channel of the current or most recent grant.

## Operation
- States:
  - IDLE: all SSP outputs low.
  - SHIFT: bits in flight.
  - GAP: 8 idle cycles after each frame.
- Reset values: every output is 0. The round-robin pointer is set so channel 0 wins first.
- IDLE→SHIFT: the state changes when enable is high and any req is sampled high in a cycle.
  - If only one channel requests, that channel is granted.
  - If both request, the channel not granted last wins.
  - The granted data byte is loaded into the shift register.
- In SHIFT, a 3-bit phase counter runs 0..7 for each bit.
  - ssp_clk is low for phases 0–3 and high for phases 4–7.
  - ssp_din takes the current MSB at phase 0 and holds it for 8 cycles.
  - At phase 4 (ssp_clk rising), ssp_dout is shifted into the rx shift register.
  - On the 7→0 phase wrap, the tx register shifts left and the bit index increments.
- ssp_frame is high for all 8 cycles of bit 0 and low otherwise.
- SHIFT→GAP happens after phase 7 of the last bit. On that transition, rx_data is loaded and rx_valid pulses.
- GAP→IDLE happens after 8 cycles. During GAP, ssp_clk, ssp_frame and ssp_din are held low.
- A req that drops before it is granted is simply not granted. A req that stays high after its ack is treated as a new request.

## Timing
- A req first sampled high in IDLE at cycle N gives:
  - ack, ssp_frame high and the first ssp_din bit at cycle N+1;
  - busy high from cycle N+1.
- The first ssp_clk rising edge is at N+5.
- The frame is 64 cycles (8 bits × 8 cycles). rx_valid is at N+65. GAP occupies N+65..N+72 and IDLE is reached at N+73.
- Minimum spacing between consecutive acks is 73 cycles. With continuous requests on both channels, acks alternate ch0, ch1, ch0, …
- enable falling mid-frame: the frame and its GAP complete, then the block stays in IDLE.
- rst asserted mid-frame: all outputs go to 0 asynchronously, the frame is aborted, and neither rx_valid nor ack is issued. After release, the pointer favours channel 0.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- SSP_ARB_TAG_EN defined:
  - Each frame is 9 bits: bit 0 is the granted channel number, followed by data MSB-first.
  - ssp_frame is high during the tag bit.
  - The frame lasts 72 cycles and ack spacing becomes 81 cycles.
  - The first received bit is discarded, so rx_data holds the last 8 bits.
- SSP_ARB_TAG_EN undefined: 8-bit frames as described above; no tag logic is present.

## Structure
- Package ssp_arb_pkg holds:
  - the state enum (IDLE, SHIFT, GAP);
  - SSP_HALF_PERIOD = 4, SSP_GAP_CYCLES = 8, SSP_DATA_BITS = 8;
  - SSP_FRAME_BITS, which is 8 or 9 depending on the macro.
- One sub-module, ssp_bit_timer, holds the phase counter and bit index. It outputs ssp_clk, rise/wrap strobes and a last-bit flag.
- Arbitration, the shift registers and the state machine live in ssp_arbiter.

## Test plan
- Single request: after reset, req0=1 with data0=8'hA5.
  - ack0 pulses at N+1.
  - ssp_din carries 1,0,1,0,0,1,0,1 in 8-cycle bits.
  - ssp_frame is high for cycles N+1..N+8 only; busy is low again at N+73.
- Contention: req0 and req1 held high with data 8'h11 and 8'h22.
  - Acks run ch0, ch1, ch0, ch1, 73 cycles apart.
  - grant_ch follows the grants; the bytes appear on ssp_din in that order.
- Receive: during an 8'h00 frame, the ARM drives ssp_dout with the pattern 8'hDE, changing it on ssp_clk falling edges.
  - rx_valid pulses once at N+65 with rx_data=8'hDE.
- Enable: enable drops at N+20 of a frame while req1 stays high.
  - The current frame completes; no further ack occurs.
  - When enable rises again, ack1 follows within 2 cycles once IDLE is reached.
- Reset: rst is pulsed at N+30 of a frame.
  - All outputs are 0 immediately; no rx_valid is issued.
  - With req0 and req1 both high after release, channel 0 is granted first.
- Tag build (SSP_ARB_TAG_EN): req1 with 8'hFF.
  - The first bit is 1 with ssp_frame high, followed by eight 1s.
  - The next ack comes 81 cycles later.
